// File: rtl/audio_pkg.sv
// Shared constants, sample type and slot-bit helper for the I2S transmitter.
package audio_pkg;

    localparam int SAMPLE_W   = 16;
    localparam int SLOT_W     = 32;
    localparam int FRAME_BITS = 64;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    localparam logic [5:0] FRAME_START = 6'd0;

    // Bit j of a 32-bit slot: MSB-first sample in j=0..15, zero padding after.
    function automatic logic slot_bit(input sample_t sample, input logic [4:0] j);
        logic [3:0] idx;
        idx = 4'd15 - j[3:0];
        return (j < 5'd16) ? sample[idx] : 1'b0;
    endfunction

endpackage

// File: rtl/audio_i2s_tx_if.sv
// Sample source handshake plus I2S serial pins; master = transmitter side.
interface audio_i2s_tx_if;
    import audio_pkg::*;

    sample_t left_in;
    sample_t right_in;
    logic    sample_ack;
    logic    aud_bclk;
    logic    aud_daclrck;
    logic    aud_dacdat;

    modport master (
        input  left_in, right_in,
        output sample_ack, aud_bclk, aud_daclrck, aud_dacdat
    );

    modport slave (
        output left_in, right_in,
        input  sample_ack, aud_bclk, aud_daclrck, aud_dacdat
    );

endinterface

// File: rtl/audio_bclk_gen.sv
// Bit-clock divider: BCLK = clk/(2*BCLK_HALF), plus a strobe on each BCLK falling edge.
module audio_bclk_gen #(
    parameter int BCLK_HALF = 8
) (
    input  logic clk,
    input  logic reset,
    output logic bclk,
    output logic fall_en
);

    localparam int CNT_W = (BCLK_HALF > 2) ? $clog2(BCLK_HALF) : 1;

    logic [CNT_W-1:0] div_cnt;
    logic             tc;

    assign tc      = (div_cnt == CNT_W'(BCLK_HALF - 1));
    // High for the clk in which bclk is about to drop 1->0.
    assign fall_en = tc & bclk;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else if (tc) begin
            div_cnt <= '0;
            bclk    <= ~bclk;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/audio_i2s_tx.sv
// Philips I2S master transmitter for 16-bit stereo samples (64 BCLK per frame).
// Define AUDIO_I2S_MONO_EN to send the average of left/right in both slots.
module audio_i2s_tx #(
    parameter int BCLK_HALF = 8,
    parameter int SAMPLE_W  = 16
) (
    input  logic           clk,
    input  logic           reset,
    audio_i2s_tx_if.master bus
);
    import audio_pkg::*;

    if (BCLK_HALF < 2) begin : g_bad_bclk_half
        $error("audio_i2s_tx: BCLK_HALF must be >= 2");
    end
    if (SAMPLE_W != audio_pkg::SAMPLE_W) begin : g_bad_sample_w
        $error("audio_i2s_tx: SAMPLE_W is fixed at 16");
    end

    logic       bclk;
    logic       fall_en;
    logic [5:0] bit_cnt;
    logic [5:0] k;
    logic [5:0] m;
    logic       ser_bit;
    sample_t    shadow_l, shadow_r;
    sample_t    cap_l, cap_r;
    logic       lrck_q, dat_q, ack_q;

    audio_bclk_gen #(.BCLK_HALF(BCLK_HALF)) u_bclk_gen (
        .clk     (clk),
        .reset   (reset),
        .bclk    (bclk),
        .fall_en (fall_en)
    );

`ifdef AUDIO_I2S_MONO_EN
    logic [SAMPLE_W:0] mono_sum;

    // 17-bit sum cannot overflow; dropping bit 0 is the arithmetic >>>1.
    assign mono_sum = {bus.left_in[SAMPLE_W-1], bus.left_in}
                    + {bus.right_in[SAMPLE_W-1], bus.right_in};
    assign cap_l    = sample_t'(mono_sum[SAMPLE_W:1]);
    assign cap_r    = sample_t'(mono_sum[SAMPLE_W:1]);
`else
    assign cap_l = bus.left_in;
    assign cap_r = bus.right_in;
`endif

    // k is the frame position being entered; m lags it by one BCLK so each
    // slot's MSB follows its LRCK transition by one bit.
    assign k       = bit_cnt + 6'd1;
    assign m       = k - 6'd1;
    assign ser_bit = m[5] ? slot_bit(shadow_r, m[4:0]) : slot_bit(shadow_l, m[4:0]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt  <= 6'd63;
            lrck_q   <= 1'b0;
            dat_q    <= 1'b0;
            ack_q    <= 1'b0;
            shadow_l <= '0;
            shadow_r <= '0;
        end else begin
            ack_q <= 1'b0;
            if (fall_en) begin
                bit_cnt <= k;
                lrck_q  <= k[5];
                dat_q   <= ser_bit;
                // The bit driven at k=0 is right-slot padding, so the new
                // shadow is first consumed at k=1.
                if (k == FRAME_START) begin
                    shadow_l <= cap_l;
                    shadow_r <= cap_r;
                    ack_q    <= 1'b1;
                end
            end
        end
    end

    assign bus.aud_bclk    = bclk;
    assign bus.aud_daclrck = lrck_q;
    assign bus.aud_dacdat  = dat_q;
    assign bus.sample_ack  = ack_q;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Scoreboard bench: stimulus queues expected frames, an I2S receiver model decodes and compares.
module tb_audio_i2s_tx;

    localparam int BH        = 8;
    localparam int BH2       = 2;
    localparam int FRAME     = 128 * BH;
    localparam int NF        = 14;
    localparam int RST_FRAME = 6;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    audio_i2s_tx_if bus ();
    audio_i2s_tx_if bus2 ();

    audio_i2s_tx #(.BCLK_HALF(BH))  dut  (.clk(clk), .reset(reset), .bus(bus));
    audio_i2s_tx #(.BCLK_HALF(BH2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

    int checks = 0;
    int errors = 0;
    int frames_checked = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected {left_word, right_word} as heard by the CODEC for captured inputs.
    function automatic logic [31:0] model(input logic [31:0] lr);
`ifdef AUDIO_I2S_MONO_EN
        int s;
        s = (int'($signed(lr[31:16])) + int'($signed(lr[15:0]))) >>> 1;
        return {s[15:0], s[15:0]};
`else
        return lr;
`endif
    endfunction

    // Receiver for the main DUT: timing of ack/bclk and frame decoding on BCLK rises.
    int since, run;
    bit first_ack, first_run, synced, prev_bclk, prev_ack;
    logic [5:0] p;
    logic [15:0] lw, rw;
    logic [31:0] e;

    always @(posedge clk) begin
        #1;
        if (reset) begin
            since = 0; run = 0; first_ack = 1; first_run = 1;
            synced = 0; prev_bclk = 0; prev_ack = 0; p = 6'd0;
            exp_q.delete();
        end else begin
            since++;
            if (bus.sample_ack) begin
                chk("ack_width", 32'(prev_ack), 32'd0);
                if (first_ack) chk("ack_first", since, 2 * BH);
                else           chk("ack_period", since, FRAME);
                since = 0; first_ack = 0; synced = 1; p = 6'd0;
            end
            if (bus.aud_bclk == prev_bclk) run++;
            else begin
                if (!first_run) chk("bclk_half", run, BH);
                first_run = 0; run = 1;
            end
            if (bus.aud_bclk && !prev_bclk && synced) begin
                chk("lrck", 32'(bus.aud_daclrck), 32'(p[5]));
                if (p >= 6'd1 && p <= 6'd16)       lw = {lw[14:0], bus.aud_dacdat};
                else if (p >= 6'd33 && p <= 6'd48) rw = {rw[14:0], bus.aud_dacdat};
                else chk("pad_zero", 32'(bus.aud_dacdat), 32'd0);
                if (p == 6'd48) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL frame: word decoded with no expected frame queued");
                    end else begin
                        e = exp_q.pop_front();
                        chk("left_word", 32'(lw), 32'(e[31:16]));
                        chk("right_word", 32'(rw), 32'(e[15:0]));
                        frames_checked++;
                    end
                end
                p = p + 6'd1;
            end
            prev_bclk = bus.aud_bclk;
            prev_ack  = bus.sample_ack;
        end
    end

    // Timing-only monitor for the fastest legal divider.
    int since2, run2, acks2 = 0;
    bit f2a, f2r, pb2, plr2;

    always @(posedge clk) begin
        #1;
        if (reset) begin
            since2 = 0; run2 = 0; f2a = 1; f2r = 1; pb2 = 0; plr2 = 0;
        end else begin
            since2++;
            if (bus2.sample_ack) begin
                if (f2a) chk("dut2_ack_first", since2, 2 * BH2);
                else     chk("dut2_ack_period", since2, 128 * BH2);
                f2a = 0; since2 = 0; acks2++;
            end
            if (bus2.aud_bclk == pb2) run2++;
            else begin
                if (!f2r) chk("dut2_bclk_half", run2, BH2);
                f2r = 0; run2 = 1;
            end
            if (bus2.aud_daclrck != plr2)
                chk("dut2_lrck_on_fall", 32'({pb2, bus2.aud_bclk}), 32'b10);
            pb2  = bus2.aud_bclk;
            plr2 = bus2.aud_daclrck;
        end
    end

    task automatic wait_ack(output bit ok);
        ok = 0;
        for (int n = 0; n < 3 * FRAME; n++) begin
            @(negedge clk);
            if (bus.sample_ack) begin
                ok = 1;
                return;
            end
        end
        checks++; errors++;
        $display("FAIL ack_timeout: no sample_ack within %0d clks", 3 * FRAME);
    endtask

    task automatic set_inputs(input logic [31:0] lr);
        bus.left_in  = lr[31:16];
        bus.right_in = lr[15:0];
    endtask

    logic [31:0] plan[$];
    bit ok;

    initial begin
        plan = '{32'hA5C3_0F01, 32'h1234_5A5A, 32'hFFFF_8001,
                 32'h7FFF_7FFF, 32'h8000_7FFF, 32'h0003_0000};
        while (plan.size() < NF) plan.push_back($urandom);
        set_inputs(plan[0]);
        bus2.left_in  = 16'h4321;
        bus2.right_in = 16'h8765;

        repeat (3) @(negedge clk);
        chk("rst_bclk", 32'(bus.aud_bclk), 32'd0);
        chk("rst_lrck", 32'(bus.aud_daclrck), 32'd0);
        chk("rst_dat",  32'(bus.aud_dacdat), 32'd0);
        chk("rst_ack",  32'(bus.sample_ack), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < NF; i++) begin
            wait_ack(ok);
            if (!ok) break;
            exp_q.push_back(model(plan[i]));
            if (i == RST_FRAME) begin
                repeat (40 * 2 * BH) @(negedge clk);
                reset = 1'b1;
                #1;
                chk("midrst_bclk", 32'(bus.aud_bclk), 32'd0);
                chk("midrst_lrck", 32'(bus.aud_daclrck), 32'd0);
                chk("midrst_dat",  32'(bus.aud_dacdat), 32'd0);
                chk("midrst_ack",  32'(bus.sample_ack), 32'd0);
                set_inputs(plan[i+1]);
                repeat (3) @(negedge clk);
                reset = 1'b0;
            end else if (i < NF - 1) begin
                // Mid-frame junk then the next frame's value; only the value
                // present at the next frame start may appear on the wire.
                repeat ($urandom_range(5, 400)) @(negedge clk);
                set_inputs($urandom);
                repeat ($urandom_range(5, 400)) @(negedge clk);
                set_inputs(plan[i+1]);
            end
        end
        repeat (FRAME + 20) @(negedge clk);
        chk("frames_checked", frames_checked, NF - 1);
        chk("dut2_enough_frames", 32'(acks2 >= 10), 32'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
